// File: rtl/jpeg_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_quantizer
//  Description : Streaming 8x8 DCT coefficient quantizer. Each coefficient is
//                multiplied by a runtime-loadable reciprocal (2^FRAC / Q),
//                rounded half-up and saturated. Three-stage pipeline with a
//                global stall driven by downstream backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_quantizer #(
    parameter int  IN_W       = 11,
    parameter int  OUT_W      = 11,
    parameter int  RECIP_W    = 16,
    parameter int  FRAC       = 12,
    parameter int  NUM_TABLES = 2,
    localparam int TS_W       = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [TS_W-1:0]    in_tsel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [5:0]         out_idx,
    output logic               out_last,
    output logic               out_sat,
    input  logic               cfg_we,
    input  logic [TS_W-1:0]    cfg_tsel,
    input  logic [5:0]         cfg_addr,
    input  logic [RECIP_W-1:0] cfg_recip,
    output logic               cfg_err,
    output logic               busy
);

    // Product width: signed IN_W times zero-extended RECIP_W.
    localparam int PW = IN_W + RECIP_W + 1;
    // Width of the rounded value before saturation.
    localparam int RW = PW + 1 - FRAC;

    localparam logic [TS_W:0]          NT        = (TS_W+1)'(NUM_TABLES);
    localparam logic [RECIP_W-1:0]     RECIP_ONE = RECIP_W'(1) << FRAC;
    localparam logic [PW:0]            RND       = (PW+1)'(1) << (FRAC - 1);
    localparam logic signed [RW-1:0]   SAT_MAX   = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0]   SAT_MIN   = ~SAT_MAX;

    // Reciprocal tables
    logic [RECIP_W-1:0] tbl_q [NUM_TABLES][64];

    // Input side state
    logic [5:0]          idx_q,  idx_d;
    logic [TS_W-1:0]     tsel_q, tsel_d;

    // Stage 1: coefficient, index, reciprocal
    logic                s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]     s1_data_q,  s1_data_d;
    logic [5:0]          s1_idx_q,   s1_idx_d;
    logic [RECIP_W-1:0]  s1_recip_q, s1_recip_d;

    // Stage 2: product
    logic                s2_valid_q, s2_valid_d;
    logic [PW-1:0]       s2_prod_q,  s2_prod_d;
    logic [5:0]          s2_idx_q,   s2_idx_d;

    // Stage 3: output registers
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q,  out_data_d;
    logic [5:0]          out_idx_q,   out_idx_d;
    logic                out_last_q,  out_last_d;
    logic                out_sat_q,   out_sat_d;
    logic                cfg_err_q,   cfg_err_d;

    // Combinational helpers
    logic                stall;
    logic                accept;
    logic                tbl_we;
    logic [TS_W-1:0]     tsel_in;
    logic [TS_W-1:0]     tsel_cur;
    logic [RECIP_W-1:0]  recip_rd;
    logic signed [PW-1:0] prod;
    logic signed [PW:0]  sum;
    logic signed [RW-1:0] rnd_r;
    logic                sat_hi;
    logic                sat_lo;
    logic [OUT_W-1:0]    sat_data;

    // Handshake, table lookup and arithmetic datapath
    always_comb begin
        stall    = out_valid_q && !out_ready;
        accept   = in_valid && !stall;
        busy     = (idx_q != 6'd0) || s1_valid_q || s2_valid_q || out_valid_q;
        // Out-of-range table selects fall back to table 0.
        tsel_in  = ({1'b0, in_tsel} < NT) ? in_tsel : '0;
        tsel_cur = (idx_q == 6'd0) ? tsel_in : tsel_q;
        recip_rd = tbl_q[tsel_cur][idx_q];
        prod     = $signed({{(RECIP_W+1){s1_data_q[IN_W-1]}}, s1_data_q}) *
                   $signed({{IN_W{1'b0}}, s1_recip_q});
        sum      = $signed({s2_prod_q[PW-1], s2_prod_q}) + $signed(RND);
        rnd_r    = RW'(sum >>> FRAC);
        sat_hi   = rnd_r > SAT_MAX;
        sat_lo   = rnd_r < SAT_MIN;
        if (sat_hi) begin
            sat_data = SAT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            sat_data = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_data = rnd_r[OUT_W-1:0];
        end
        // Table writes only land while fully idle and not accepting.
        tbl_we    = cfg_we && !busy && !accept && ({1'b0, cfg_tsel} < NT);
        cfg_err_d = cfg_we && !tbl_we;
    end

    // Next-state for the index counter and pipeline; everything holds on stall
    always_comb begin
        idx_d       = idx_q;
        tsel_d      = tsel_q;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_idx_d    = s1_idx_q;
        s1_recip_d  = s1_recip_q;
        s2_valid_d  = s2_valid_q;
        s2_prod_d   = s2_prod_q;
        s2_idx_d    = s2_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_sat_d   = out_sat_q;
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_data_d  = in_data;
                s1_idx_d   = idx_q;
                s1_recip_d = recip_rd;
                idx_d      = idx_q + 6'd1;
                if (idx_q == 6'd0) begin
                    tsel_d = tsel_in;
                end
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d = prod;
                s2_idx_d  = s1_idx_q;
            end
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = sat_data;
                out_idx_d  = s2_idx_q;
                out_last_d = (s2_idx_q == 6'd63);
                out_sat_d  = sat_hi || sat_lo;
            end
        end
    end

    // Pipeline and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            tsel_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_idx_q    <= '0;
            s1_recip_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            tsel_q      <= tsel_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_idx_q    <= s1_idx_d;
            s1_recip_q  <= s1_recip_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_idx_q    <= s2_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_sat_q   <= out_sat_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Reciprocal table storage; reset loads Q=1 everywhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                for (int a = 0; a < 64; a++) begin
                    tbl_q[t][a] <= RECIP_ONE;
                end
            end
        end else if (tbl_we) begin
            tbl_q[cfg_tsel][cfg_addr] <= cfg_recip;
        end
    end

    // Output drive
    always_comb begin
        in_ready  = !stall;
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_idx   = out_idx_q;
        out_last  = out_last_q;
        out_sat   = out_sat_q;
        cfg_err   = cfg_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_quantizer
//  Description : Self-checking bench for jpeg_quantizer with a behavioural
//                reference model and directed plus randomized blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_quantizer;

    localparam int IN_W       = 11;
    localparam int OUT_W      = 11;
    localparam int RECIP_W    = 16;
    localparam int FRAC       = 12;
    localparam int NUM_TABLES = 2;
    localparam int TS_W       = 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [IN_W-1:0]   in_data = '0;
    logic [TS_W-1:0]          in_tsel = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [OUT_W-1:0]  out_data;
    logic [5:0]               out_idx;
    logic                     out_last;
    logic                     out_sat;
    logic                     cfg_we = 1'b0;
    logic [TS_W-1:0]          cfg_tsel = '0;
    logic [5:0]               cfg_addr = '0;
    logic [RECIP_W-1:0]       cfg_recip = '0;
    logic                     cfg_err;
    logic                     busy;

    jpeg_quantizer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .RECIP_W(RECIP_W),
        .FRAC(FRAC), .NUM_TABLES(NUM_TABLES)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tsel(in_tsel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
        .cfg_we(cfg_we), .cfg_tsel(cfg_tsel), .cfg_addr(cfg_addr), .cfg_recip(cfg_recip),
        .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint data;
        int     idx;
        bit     sat;
    } exp_t;

    longint mtbl [NUM_TABLES][64];
    int     midx;
    int     mtsel;
    exp_t   q[$];
    bit     exp_err;

    // Captured outputs of the current block, for literal checks
    longint got_data [64];
    bit     got_sat  [64];
    int     n_out, n_last, n_sat;
    int     cyc = 0;
    bit     lat_arm = 0;
    int     first_acc = -1;
    int     first_ov  = -1;

    function automatic exp_t model_beat(longint d, longint recip, int idx);
        exp_t   e;
        real    v;
        longint r;
        longint hi;
        longint lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        v = $floor((real'(d * recip) + 2.0 ** (FRAC - 1)) / (2.0 ** FRAC));
        r = longint'(v);
        e.sat = 1'b0;
        if (r > hi) begin r = hi; e.sat = 1'b1; end
        if (r < lo) begin r = lo; e.sat = 1'b1; end
        e.data = r;
        e.idx  = idx;
        return e;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < NUM_TABLES; t++)
            for (int a = 0; a < 64; a++)
                mtbl[t][a] = longint'(1) << FRAC;
        midx    = 0;
        mtsel   = 0;
        exp_err = 0;
        q.delete();
    endtask

    // Single compare process: looks at what the coming edge will do
    always @(negedge clk) begin
        bit   acc, ok, mbusy;
        int   t;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            mbusy = (midx != 0) || (q.size() != 0);
            chk("busy", busy, mbusy);
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            chk("cfg_err", cfg_err, exp_err);
            acc = in_valid && in_ready;
            if (lat_arm && acc && first_acc < 0) first_acc = cyc;
            if (lat_arm && out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk("out_data", out_data, q[0].data);
                    chk("out_idx", out_idx, q[0].idx);
                    chk("out_last", out_last, q[0].idx == 63);
                    chk("out_sat", out_sat, q[0].sat);
                    if (out_ready) begin
                        got_data[out_idx] = out_data;
                        got_sat[out_idx]  = out_sat;
                        n_out++;
                        n_last += int'(out_last);
                        n_sat  += int'(out_sat);
                        void'(q.pop_front());
                    end
                end
            end
            ok = cfg_we && !mbusy && !acc && (int'(cfg_tsel) < NUM_TABLES);
            exp_err = cfg_we && !ok;
            if (ok) mtbl[cfg_tsel][cfg_addr] = longint'(cfg_recip);
            if (acc) begin
                if (midx == 0) begin
                    mtsel = (int'(in_tsel) < NUM_TABLES) ? int'(in_tsel) : 0;
                end
                t = mtsel;
                q.push_back(model_beat(longint'(in_data), mtbl[t][midx], midx));
                midx = (midx + 1) % 64;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic signed [IN_W-1:0] blk [64];
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: manual
    bit gaps = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 0) out_ready = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic signed [IN_W-1:0] d, input logic [TS_W-1:0] t);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tsel  = t;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int tsel0, input int lo, input int hi);
        logic [TS_W-1:0] t;
        for (int i = lo; i <= hi; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            t = (i == 0) ? TS_W'(tsel0) : TS_W'(i % 2);
            send_beat(blk[i], t);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int tsel0);
        n_out = 0; n_last = 0; n_sat = 0;
        send_range(tsel0, 0, 63);
        wait_idle();
    endtask

    task automatic cfg_write(input int t, input int a, input int v);
        cfg_we    = 1'b1;
        cfg_tsel  = TS_W'(t);
        cfg_addr  = 6'(a);
        cfg_recip = RECIP_W'(v);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) blk[i] = IN_W'(i - 32);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) blk[i] = IN_W'(int'($urandom_range(0, 2047)) - 1024);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 64; i++) blk[i] = IN_W'(v);
    endtask

    function automatic int count_diff(input int want);
        int m = 0;
        for (int i = 0; i < 64; i++) if (got_data[i] != longint'(want)) m++;
        return m;
    endfunction

    function automatic int count_ramp_diff();
        int m = 0;
        for (int i = 0; i < 64; i++) if (got_data[i] != longint'(i - 32)) m++;
        return m;
    endfunction

    initial begin
        logic signed [OUT_W-1:0] sd;
        logic [5:0]              si;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Default tables: identity, 3-cycle latency
        fill_ramp();
        lat_arm = 1;
        run_block(0);
        lat_arm = 0;
        chk("latency", first_ov - first_acc, 3);
        chk("ramp_count", n_out, 64);
        chk("ramp_last_count", n_last, 1);
        chk("ramp_sat_count", n_sat, 0);
        chk("ramp_idx0", got_data[0], -32);
        chk("ramp_idx63", got_data[63], 31);
        chk("ramp_all", count_ramp_diff(), 0);

        // Q=16 at position 0: rounding
        cfg_write(0, 0, 256);
        fill_random(); blk[0] = 100;
        run_block(0);
        chk("q16_100", got_data[0], 6);
        fill_random(); blk[0] = -24;
        run_block(0);
        chk("q16_m24", got_data[0], -1);
        fill_random(); blk[0] = 8;
        run_block(0);
        chk("q16_8", got_data[0], 1);

        // Saturation at position 5
        cfg_write(0, 5, 8192);
        fill_random(); blk[5] = 1000;
        run_block(0);
        chk("sat_pos_data", got_data[5], 1023);
        chk("sat_pos_flag", got_sat[5], 1);
        fill_random(); blk[5] = -1024;
        run_block(0);
        chk("sat_neg_data", got_data[5], -1024);
        chk("sat_neg_flag", got_sat[5], 1);
        fill_random(); blk[5] = 500;
        run_block(0);
        chk("nosat_data", got_data[5], 1000);
        chk("nosat_flag", got_sat[5], 0);

        // Table select
        cfg_write(0, 0, 4096);
        cfg_write(0, 5, 4096);
        for (int a = 0; a < 64; a++) cfg_write(1, a, 1024);
        fill_const(40);
        run_block(0);
        chk("tsel0_block", count_diff(40), 0);
        run_block(1);
        chk("tsel1_block", count_diff(10), 0);
        chk("tsel1_count", n_out, 64);

        // Backpressure: five stalled cycles mid-block
        rdy_mode = 2;
        out_ready = 1'b1;
        fill_random();
        n_out = 0;
        fork
            send_range(0, 0, 63);
            begin
                repeat (25) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("stall_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                sd = out_data;
                si = out_idx;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_data_stable", out_data, sd);
                    chk("stall_idx_stable", out_idx, si);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("stall_count", n_out, 64);
        rdy_mode = 0;

        // Config write while busy is rejected
        fill_const(40);
        n_out = 0;
        send_range(1, 0, 9);
        cfg_write(1, 3, 1);
        chk("busy_cfg_err_pulse", cfg_err, 1);
        @(posedge clk);
        #1;
        chk("busy_cfg_err_clear", cfg_err, 0);
        send_range(1, 10, 63);
        wait_idle();
        run_block(1);
        chk("busy_cfg_unchanged", got_data[3], 10);

        // Reset mid-block
        fill_ramp();
        send_range(1, 0, 29);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_block(1);
        chk("postrst_count", n_out, 64);
        chk("postrst_identity", count_ramp_diff(), 0);

        // Randomized blocks with random tables and backpressure
        rdy_mode = 1;
        gaps = 1;
        for (int b = 0; b < 6; b++) begin
            repeat ($urandom_range(1, 4)) begin
                int sel;
                int v;
                sel = int'($urandom_range(0, 3));
                v = (sel == 0) ? 0 : (sel == 1) ? 4096 : int'($urandom_range(1, 65535));
                cfg_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)), v);
            end
            fill_random();
            run_block(int'($urandom_range(0, 1)));
            chk("rand_count", n_out, 64);
        end
        rdy_mode = 0;
        gaps = 0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
